mem_store_checker: RTL and testbench



---
 rtl/mem_store_checker.sv | 115 +++++++++++
 tb/tb_mem_store_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_checker.sv
// mem_store_checker
//   Watches the processor store bus and decides whether a test program
//   passes or fails. After reset the block spends one cycle in IDLE and
//   then enters RUN. While in RUN it accepts stores:
//     - a store to ALLOW_ADDR keeps the run going,
//     - a store to PASS_ADDR ends the run; the data decides pass or fail,
//     - a store to any other address ends the run as a failure.
//   If no store ends the run within TIMEOUT RUN cycles, the run fails.
//   PASS and FAIL are sticky until reset, and every statistic freezes there.
//
// Ports
//   clk          rising-edge clock shared with the processor
//   reset        asynchronous reset, active low
//   memwrite     store strobe
//   dataadr      store address (32 bits)
//   writedata    store data (32 bits)
//   done         run finished (pass or fail)
//   pass         run finished successfully
//   fail_code    00 none, 01 illegal address, 10 wrong pass data, 11 timeout
//   cycle_count  clock cycles spent in RUN, saturating
//   store_count  stores accepted in RUN, saturating
//   last_addr    address of the most recent store accepted in RUN
module mem_store_checker #(
    parameter logic [31:0] PASS_ADDR  = 32'd84,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] ALLOW_ADDR = 32'd80,
    parameter logic [31:0] TIMEOUT    = 32'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] cycle_count,
    output logic [15:0] store_count,
    output logic [31:0] last_addr
);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_DATA    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    state_t      state, state_d;
    logic [1:0]  fc_d;
    logic [31:0] cyc_d, last_d, cyc_inc;
    logic [15:0] sc_d, sc_inc;

    assign cyc_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    assign sc_inc  = (store_count == 16'hFFFF) ? store_count : store_count + 16'd1;

    always_comb begin
        state_d = state;
        fc_d    = fail_code;
        cyc_d   = cycle_count;
        sc_d    = store_count;
        last_d  = last_addr;
        case (state)
            IDLE: state_d = RUN;   // memwrite deliberately ignored here
            RUN: begin
                cyc_d = cyc_inc;   // the terminating cycle is counted too
                if (memwrite) begin
                    last_d = dataadr;
                    sc_d   = sc_inc;
                    if (dataadr == PASS_ADDR) begin
                        if (writedata == PASS_DATA) begin
                            state_d = PASS;
                        end else begin
                            state_d = FAIL;
                            fc_d    = FC_DATA;
                        end
                    end else if (dataadr != ALLOW_ADDR) begin
                        state_d = FAIL;
                        fc_d    = FC_ILLEGAL;
                    end
                end
                // Timeout only applies when no store ended the run this
                // cycle, so a terminating store on the last cycle wins.
                if (state_d == RUN && cyc_inc >= TIMEOUT) begin
                    state_d = FAIL;
                    fc_d    = FC_TIMEOUT;
                end
            end
            default: ;             // PASS / FAIL hold everything
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
            cycle_count <= '0;
            store_count <= '0;
            last_addr   <= '0;
        end else begin
            state       <= state_d;
            // done/pass are flopped from the next state so they line up
            // with the state register instead of being decoded after it.
            done        <= (state_d == PASS) || (state_d == FAIL);
            pass        <= (state_d == PASS);
            fail_code   <= fc_d;
            cycle_count <= cyc_d;
            store_count <= sc_d;
            last_addr   <= last_d;
        end
    end

endmodule

// File: tb/tb_mem_store_checker.sv
// Testbench for mem_store_checker (TIMEOUT shortened to 20).
// Each run is described as a per-RUN-cycle list of stores; a sequence-level
// reference model replays that list to predict the final outputs.
module tb_mem_store_checker;

    localparam logic [31:0] PA = 32'd84;
    localparam logic [31:0] PD = 32'd7;
    localparam logic [31:0] AA = 32'd80;
    localparam int          TO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        done, pass;
    logic [1:0]  fail_code;
    logic [31:0] cycle_count, last_addr;
    logic [15:0] store_count;

    int checks = 0;
    int errors = 0;

    logic        seq_mw  [0:63];
    logic [31:0] seq_adr [0:63];
    logic [31:0] seq_dat [0:63];
    int          seq_len;

    mem_store_checker #(
        .PASS_ADDR(PA), .PASS_DATA(PD), .ALLOW_ADDR(AA), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .done(done), .pass(pass), .fail_code(fail_code),
        .cycle_count(cycle_count), .store_count(store_count), .last_addr(last_addr)
    );

    always #5 clk = ~clk;

    // {done, pass, fail_code, cycle_count, store_count, last_addr}
    function automatic logic [83:0] outs();
        return {done, pass, fail_code, cycle_count, store_count, last_addr};
    endfunction

    function automatic logic [83:0] pack(input logic d, input logic p, input logic [1:0] fc,
                                         input int cyc, input int sc, input logic [31:0] la);
        return {d, p, fc, 32'(cyc), 16'(sc), la};
    endfunction

    // Replays the store list: run ends on the first store to PA, the first
    // store outside {PA, AA}, or after TO RUN cycles, whichever comes first.
    function automatic logic [83:0] model();
        bit ended = 0;
        logic p = 0;
        logic [1:0] fc = 0;
        int cyc = 0, sc = 0;
        logic [31:0] la = 0;
        for (int k = 0; k < seq_len; k++) begin
            if (ended) break;
            cyc++;
            if (seq_mw[k]) begin
                sc++;
                la = seq_adr[k];
                if (seq_adr[k] == PA) begin
                    ended = 1;
                    if (seq_dat[k] == PD) p = 1; else fc = 2'b10;
                end else if (seq_adr[k] != AA) begin
                    ended = 1;
                    fc = 2'b01;
                end
            end
            if (!ended && cyc >= TO) begin
                ended = 1;
                fc = 2'b11;
            end
        end
        return pack(ended, p, fc, cyc, sc, la);
    endfunction

    task automatic clear_seq(input int len);
        seq_len = len;
        for (int k = 0; k < 64; k++) begin
            seq_mw[k] = 0; seq_adr[k] = '0; seq_dat[k] = '0;
        end
    endtask

    task automatic set_store(input int k, input logic [31:0] a, input logic [31:0] d);
        seq_mw[k] = 1; seq_adr[k] = a; seq_dat[k] = d;
    endtask

    // Leaves reset released at a negedge; the following posedge is the IDLE edge.
    task automatic do_reset();
        reset = 0; memwrite = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    // Drives one list entry per RUN cycle, then idles the bus at a negedge.
    task automatic drive_seq();
        for (int k = 0; k < seq_len; k++) begin
            @(negedge clk);
            memwrite = seq_mw[k]; dataadr = seq_adr[k]; writedata = seq_dat[k];
        end
        @(negedge clk);
        memwrite = 0;
    endtask

    task automatic test_reset();
        reset = 0; memwrite = 1; dataadr = PA; writedata = PD;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 84'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", outs(), 84'd0);
        end
        memwrite = 0;
    endtask

    task automatic test_pass();
        logic [83:0] exp = pack(1, 1, 2'b00, 2, 2, PA);
        do_reset(); clear_seq(4);
        set_store(0, AA, 32'd5); set_store(1, PA, PD);
        drive_seq();
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL pass_run: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_wrong_data();
        logic [83:0] exp = pack(1, 0, 2'b10, 1, 1, PA);
        do_reset(); clear_seq(3);
        set_store(0, PA, 32'd6);
        drive_seq();
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL wrong_data: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_illegal();
        logic [83:0] exp = pack(1, 0, 2'b01, 1, 1, 32'd88);
        do_reset(); clear_seq(3);
        set_store(0, 32'd88, PD); set_store(2, PA, PD);
        drive_seq();
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL illegal_sticky: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_timeout();
        logic [83:0] exp = pack(1, 0, 2'b11, TO, 0, 32'd0);
        do_reset(); clear_seq(TO + 5);
        drive_seq();
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL timeout: got %h want %h", outs(), exp);
        end
        exp = pack(1, 1, 2'b00, TO, 1, PA);
        do_reset(); clear_seq(TO + 3);
        set_store(TO - 1, PA, PD); set_store(TO, 32'd88, PD);
        drive_seq();
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL timeout_tie: got %h want %h", outs(), exp);
        end
        exp = pack(1, 0, 2'b11, TO, 0, 32'd0);
        do_reset(); clear_seq(TO + 1);
        set_store(TO, PA, PD);   // one cycle too late
        drive_seq();
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL timeout_late_store: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_async_reset();
        logic [83:0] exp = pack(0, 0, 2'b00, 5, 5, AA);
        do_reset(); clear_seq(5);
        for (int k = 0; k < 5; k++) set_store(k, AA, 32'(k));
        drive_seq();
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL mid_run: got %h want %h", outs(), exp);
        end
        @(posedge clk); #1 reset = 0;
        #1;
        checks++;
        if (outs() !== 84'd0) begin
            errors++; $display("FAIL async_clear: got %h want %h", outs(), 84'd0);
        end
        #1 reset = 1;
        @(negedge clk);
        clear_seq(2); set_store(0, PA, PD);
        drive_seq();
        exp = pack(1, 1, 2'b00, 1, 1, PA);
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL after_async: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_idle_ignore();
        logic [83:0] exp;
        do_reset();
        memwrite = 1; dataadr = PA; writedata = PD;   // present across IDLE edge
        @(negedge clk);
        exp = pack(0, 0, 2'b00, 0, 0, 32'd0);
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL idle_ignore: got %h want %h", outs(), exp);
        end
        @(negedge clk);
        memwrite = 0;
        exp = pack(1, 1, 2'b00, 1, 1, PA);
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL idle_then_run: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_random();
        logic [83:0] exp;
        for (int r = 0; r < 40; r++) begin
            do_reset(); clear_seq($urandom_range(1, 26));
            for (int k = 0; k < seq_len; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int sel = $urandom_range(0, 7);
                    logic [31:0] a = (sel < 5) ? AA : (sel == 5) ? PA : (sel == 6) ? 32'd88 : $urandom;
                    logic [31:0] d = $urandom_range(0, 1) ? PD : 32'($urandom_range(0, 15));
                    set_store(k, a, d);
                end else begin
                    seq_adr[k] = $urandom;   // bus noise without strobe
                    seq_dat[k] = $urandom;
                end
            end
            drive_seq();
            exp = model();
            checks++;
            if (outs() !== exp) begin
                errors++; $display("FAIL random_run%0d: got %h want %h", r, outs(), exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_wrong_data();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_idle_ignore();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
